// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter/sequencer for a shared N:1 data mux; holds a grant for up to MAX_HOLD accepted beats.
// Latency: req -> gnt/sel one cycle; one idle bubble cycle between consecutive grants.
// Backpressure: out_ready low stalls indefinitely in BUSY; the grant persists while req[sel] stays high.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   req[N]            per-requester request, held high while the requester has data
//   din[N*W]          packed requester data, requester k at [k*W +: W]
//   gnt[N], sel[SW]   registered one-hot grant / binary select of the granted requester
//   out_valid/out_data/out_ready  valid/ready output channel fed through the mux
//   ack[N]            one-cycle pulse on bit sel for every accepted beat

module rr_mux_arbiter #(
  parameter  int N        = 4,
  parameter  int W        = 8,
  parameter  int MAX_HOLD = 4,
  localparam int SW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] din,
  output logic [N-1:0]   gnt,
  output logic [SW-1:0]  sel,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  input  logic           out_ready,
  output logic [N-1:0]   ack
);

  // Beat counter wide enough for MAX_HOLD up to 255.
  localparam int CW = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_gnt;
  logic [SW-1:0]   r_sel;
  logic [SW-1:0]   r_ptr;
  logic [CW-1:0]   r_beat_cnt;

  logic [W-1:0]    w_din_arr [N];
  logic            w_found;
  logic [SW-1:0]   w_win;
  logic [N-1:0]    w_win_onehot;
  logic [SW:0]     w_sum;
  logic            w_sel_req;
  logic            w_accept;
  logic            w_last_beat;
  logic [SW-1:0]   w_ptr_next;

  // Unpack the flat data bus so the mux is a plain array index.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_din_arr[k] = din[k*W +: W];
    end
  end

  // Round-robin search: first set req bit at or after r_ptr, wrapping modulo N.
  // The sum is one bit wider than the pointer so ptr+i never overflows before the wrap.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, r_ptr} + (SW+1)'(i);
      if (w_sum >= (SW+1)'(N)) begin
        w_sum = w_sum - (SW+1)'(N);
      end
      if (!w_found && req[w_sum[SW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[SW-1:0];
      end
    end
  end

  assign w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win;

  // Output channel is only live while a grant is held.
  assign w_sel_req   = req[r_sel];
  assign out_valid   = (r_state == ST_BUSY) && w_sel_req;
  assign w_accept    = out_valid && out_ready;
  assign w_last_beat = (r_beat_cnt == CW'(MAX_HOLD - 1));
  assign out_data    = w_din_arr[r_sel];

  // In BUSY the grant is one-hot on sel, so it doubles as the ack mask.
  assign ack         = w_accept ? r_gnt : '0;

  assign w_ptr_next  = (r_sel == SW'(N - 1)) ? '0 : r_sel + SW'(1);

  assign gnt = r_gnt;
  assign sel = r_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state    <= ST_BUSY;
            r_gnt      <= w_win_onehot;
            r_sel      <= w_win;
            r_beat_cnt <= '0;
          end
        end
        ST_BUSY: begin
          // Leave on requester drop or on the final allowed beat; the IDLE cycle
          // that follows is the mandatory bubble between grants.
          if (!w_sel_req || (w_accept && w_last_beat)) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_ptr      <= w_ptr_next;
            r_beat_cnt <= '0;
          end else if (w_accept && (r_beat_cnt != CW'(MAX_HOLD))) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus random traffic,
// all compared every cycle against a grant-level behavioural model.
// Model tracks only "who owns the channel, how many beats taken, where the search starts".

module tb_rr_mux_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic [SW-1:0]  sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [N-1:0]   ack;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.N(N), .W(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .ack       (ack)
  );

  int tests = 0;
  int fails = 0;

  // Model: owner = granted requester or -1 when idle.
  int m_owner;
  int m_sel;
  int m_ptr;
  int m_beats;

  // Values sampled in the most recent step.
  logic [N-1:0]  c_gnt;
  logic [N-1:0]  c_ack;
  logic          c_vld;
  logic [W-1:0]  c_data;
  logic [SW-1:0] c_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_sel   = 0;
    m_ptr   = 0;
    m_beats = 0;
  endtask

  task automatic model_check();
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_ack;
    logic         e_vld;
    logic [W-1:0] e_data;
    e_gnt = '0;
    e_ack = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    e_vld  = (m_owner >= 0) && req[m_owner];
    e_data = din[m_sel*W +: W];
    if (e_vld && out_ready) e_ack[m_sel] = 1'b1;
    chk("gnt",       gnt,       e_gnt);
    chk("sel",       sel,       m_sel);
    chk("out_valid", out_valid, e_vld);
    chk("out_data",  out_data,  e_data);
    chk("ack",       ack,       e_ack);
  endtask

  task automatic model_release();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_beats = 0;
  endtask

  task automatic model_edge();
    int k;
    if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (req[k]) begin
          m_owner = k;
          m_sel   = k;
          m_beats = 0;
          break;
        end
      end
    end else if (!req[m_owner]) begin
      model_release();
    end else if (out_ready) begin
      m_beats++;
      if (m_beats == MH) model_release();
    end
  endtask

  // One clock cycle: drive at negedge, compare shortly after, advance model at posedge.
  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic rdy);
    @(negedge clk);
    req       = r;
    din       = d;
    out_ready = rdy;
    #1;
    model_check();
    c_gnt  = gnt;
    c_ack  = ack;
    c_vld  = out_valid;
    c_data = out_data;
    c_sel  = sel;
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    logic [27:0] hg;
    logic [27:0] ha;
    logic [19:0] order;
    logic [N-1:0] prev;
    logic [N-1:0] r;
    int stall;
    int nack;
    int ng;
    int idle;

    rst_n     = 1'b0;
    req       = '0;
    din       = '0;
    out_ready = 1'b0;
    model_reset();

    // Reset values
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", sel, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ack", ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    chk("idle_after_rst", c_gnt, 0);

    // Single requester: 4 beats, bubble, re-grant
    hg = '0;
    ha = '0;
    for (int i = 0; i < 7; i++) begin
      step(4'b0010, 32'h0000_A500, 1'b1);
      hg = {hg[23:0], c_gnt};
      ha = {ha[23:0], c_ack};
      if (i == 1) begin
        chk("single_sel", c_sel, 1);
        chk("single_data", c_data, 8'hA5);
      end
    end
    chk("single_gnt_seq", hg, 28'h0222202);
    chk("single_ack_seq", ha, 28'h0222202);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    chk("model_ptr_single", m_ptr, 2);

    // Backpressure on requester 2: 5 stalled cycles then 4 acks
    stall = 0;
    nack  = 0;
    for (int i = 0; i < 11; i++) begin
      step((i < 10) ? 4'b0100 : 4'b0000, $urandom, (i >= 6));
      if (i >= 1 && i <= 5 && c_gnt == 4'b0100 && c_vld && c_ack == 4'b0000) stall++;
      if (c_ack == 4'b0100) nack++;
    end
    chk("bp_stall_cycles", stall, 5);
    chk("bp_acks", nack, 4);
    chk("bp_released", c_gnt, 0);
    chk("model_ptr_bp", m_ptr, 3);

    // Priority search wraps from ptr=3: requester 0 before 2
    hg = '0;
    for (int i = 0; i < 7; i++) begin
      step(4'b0101, $urandom, 1'b1);
      hg = {hg[23:0], c_gnt};
    end
    chk("wrap_gnt_seq", hg, 28'h0111104);

    // Asynchronous reset in the middle of grant 0100
    #3;
    chk("pre_rst_gnt", gnt, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_sel", sel, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ack", ack, 0);
    model_reset();
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    chk("idle_after_midrst", c_gnt, 0);

    // Round robin with all requesting: order 0,1,2,3,0 with one idle cycle between grants
    order = '0;
    ng    = 0;
    idle  = 0;
    prev  = '0;
    for (int i = 0; i < 24; i++) begin
      step(4'b1111, $urandom, 1'b1);
      if (c_gnt != 0 && prev == 0) begin
        order = {order[15:0], 2'b00, c_sel};
        ng++;
      end
      if (c_gnt == 0 && ng > 0) idle++;
      prev = c_gnt;
    end
    chk("rr_order", order, 20'h01230);
    chk("rr_grants", ng, 5);
    chk("rr_bubbles", idle, 4);

    // Move the pointer to 2 before the early-drop case
    step(4'b0000, '0, 1'b1);
    step(4'b0010, $urandom, 1'b1);
    step(4'b0000, '0, 1'b1);
    chk("model_ptr_pre_drop", m_ptr, 2);

    // Early drop after 2 beats, then requester 1 wins over 0
    nack = 0;
    step(4'b0001, $urandom, 1'b1);
    step(4'b0001, $urandom, 1'b1);
    if (c_ack == 4'b0001) nack++;
    step(4'b0001, $urandom, 1'b1);
    if (c_ack == 4'b0001) nack++;
    chk("drop_acks", nack, 2);
    step(4'b0000, $urandom, 1'b1);
    chk("drop_gnt_held", c_gnt, 4'b0001);
    chk("drop_valid", c_vld, 0);
    step(4'b0011, $urandom, 1'b1);
    chk("drop_bubble", c_gnt, 0);
    chk("model_ptr_drop", m_ptr, 1);
    step(4'b0011, $urandom, 1'b1);
    chk("drop_next_gnt", c_gnt, 4'b0010);

    // Random traffic with sticky requests and random backpressure
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      step(r, $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
